acc_alu: RTL and testbench
==========================

ACC_ALU -- requirements
Module: acc_alu

Interface
REQ-001 Parameter: WIDTH, 16, datapath/accumulator width in bits (legal 4..32).
REQ-002 Port: clk  input  1  rising-edge clock.
REQ-003 Port: rst  input  1  reset, synchronous, active-low.
REQ-004 Port: in_valid  input  1  command present.
REQ-005 Port: in_ready  output  1  block can accept a command this cycle.
REQ-006 Port: opcode  input  4  operation select.
REQ-007 Port: in_val  input  WIDTH  operand.
REQ-008 Port: out_valid  output  1  one-cycle pulse; out_val/flags hold a new result.
REQ-009 Port: out_val  output  WIDTH  accumulator value after the last completed command.
REQ-010 Port: flag_z  output  1  out_val == 0.
REQ-011 Port: flag_c  output  1  carry (ADD) / borrow (SUB) of the last arithmetic command.
REQ-012 Port: flag_v  output  1  MUL product exceeded WIDTH bits.
REQ-013 Port: busy  output  1  multi-cycle MUL in progress; equals !in_ready.

Function
REQ-014 Command accepted on a rising edge where in_valid && in_ready; otherwise inputs are ignored.
REQ-015 Opcodes: 0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR; 10..15 execute as NOP.
REQ-016 All arithmetic is unsigned, modulo 2^WIDTH unless REQ-031 applies.
REQ-017 Single-cycle ops (all except MUL): acc, out_val and flags update on the accepting edge; out_val = new acc; out_valid = 1 for the following cycle only.
REQ-018 NOP leaves acc unchanged but still pulses out_valid (read-back); LOAD sets acc = in_val.
REQ-019 SHL/SHR: shift amount = in_val; amount >= WIDTH yields 0; zero fill.
REQ-020 flag_c updates only on ADD/SUB; flag_v only on MUL; flag_z on every completed command.
REQ-021 FSM states IDLE, MUL. IDLE -> MUL on accepted MUL; MUL -> IDLE after exactly WIDTH shift-add iterations.
REQ-022 In MUL: in_ready = 0, busy = 1; acc/out_val unchanged until completion.
REQ-023 MUL accepted on edge E0: result written to acc/out_val on edge E0+WIDTH; out_valid high in the cycle after that edge; in_ready high in that same cycle.
REQ-024 MUL result = low WIDTH bits of acc*in_val; flag_v = 1 if upper WIDTH bits nonzero.
REQ-025 Back-to-back single-cycle commands are accepted every cycle with no bubbles; out_valid then stays high continuously.
REQ-026 in_valid while busy: command not accepted; source must hold it (no internal queue).

Reset
REQ-027 rst low at a rising edge: acc, out_val, all flags, out_valid = 0; FSM = IDLE; in_ready = 1, busy = 0 from the first cycle after rst returns high.
REQ-028 Reset during MUL aborts it: no out_valid pulse, partial product discarded.
REQ-029 rst has priority over any command on the same edge; nothing is accepted while rst is low.

Configuration
REQ-030 Macro ACC_ALU_SAT_EN selects saturating arithmetic.
REQ-031 Defined: ADD overflow clamps to 2^WIDTH-1, SUB underflow clamps to 0, MUL with flag_v clamps to 2^WIDTH-1; flag_c/flag_v still report the event.
REQ-032 Undefined: ADD/SUB/MUL wrap modulo 2^WIDTH; no saturation logic present.

Verification (WIDTH=16)
REQ-033 LOAD 0x0005, ADD 0x0003 back-to-back -> out_valid two consecutive cycles, final out_val 0x0008, flag_c 0, flag_z 0.
REQ-034 LOAD 0xFFFF, ADD 0x0002 -> out_val 0x0001, flag_c 1 (no SAT); 0xFFFF, flag_c 1 (SAT); then LOAD 0, SUB 1 -> 0xFFFF / 0x0000, flag_c 1.
REQ-035 LOAD 0x0003, MUL 0x0007 -> in_ready low 16 cycles, out_valid in 17th cycle after accept, out_val 0x0015, flag_v 0; in_valid held meanwhile not accepted.
REQ-036 LOAD 0x0100, MUL 0x0100 -> flag_v 1; out_val 0x0000 with flag_z 1 (no SAT) or 0xFFFF (SAT).
REQ-037 rst low 5 cycles into a MUL -> all outputs 0, no out_valid, in_ready 1 after release; next LOAD 0x1234 -> out_val 0x1234.
REQ-038 SHL 3 on 0x0001 -> 0x0008; SHR 16 -> 0x0000, flag_z 1; opcode 12 -> acc unchanged, out_valid pulses.

Source files
------------

// File: rtl/acc_alu.sv
// rtl/acc_alu.sv - accumulator ALU with single-cycle logic/arith ops and a shift-add multiply
//
// Optional feature: define ACC_ALU_SAT_EN to make ADD/SUB/MUL saturate instead of wrapping.
//
// Parameters:
//   WIDTH      datapath / accumulator width in bits (4..32)
// Ports:
//   clk        rising-edge clock
//   rst        synchronous active-low reset
//   in_valid   command present
//   in_ready   command can be accepted this cycle (low while a MUL runs)
//   opcode     0 NOP, 1 LOAD, 2 ADD, 3 SUB, 4 MUL, 5 AND, 6 OR, 7 XOR, 8 SHL, 9 SHR, 10..15 NOP
//   in_val     operand (shift amount for SHL/SHR)
//   out_valid  one-cycle pulse when a command completes
//   out_val    accumulator value after the last completed command
//   flag_z     result of the last completed command was zero
//   flag_c     carry (ADD) / borrow (SUB) of the last ADD or SUB
//   flag_v     last MUL product did not fit in WIDTH bits
//   busy       MUL in progress, always the inverse of in_ready
module acc_alu #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [3:0]       opcode,
  input  logic [WIDTH-1:0] in_val,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_val,
  output logic             flag_z,
  output logic             flag_c,
  output logic             flag_v,
  output logic             busy
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST_ITER = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] WIDTH_V   = WIDTH'(WIDTH);

  localparam logic [3:0] OP_NOP  = 4'd0;
  localparam logic [3:0] OP_LOAD = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_SUB  = 4'd3;
  localparam logic [3:0] OP_MUL  = 4'd4;
  localparam logic [3:0] OP_AND  = 4'd5;
  localparam logic [3:0] OP_OR   = 4'd6;
  localparam logic [3:0] OP_XOR  = 4'd7;
  localparam logic [3:0] OP_SHL  = 4'd8;
  localparam logic [3:0] OP_SHR  = 4'd9;

  typedef enum logic {
    S_IDLE = 1'b0,
    S_MUL  = 1'b1
  } state_t;

  state_t state;
  state_t state_nxt;

  logic [WIDTH-1:0]   acc;
  logic [WIDTH-1:0]   mcand;
  // Upper half accumulates partial sums, lower half starts as the multiplier
  // and is shifted out one bit per iteration.
  logic [2*WIDTH-1:0] prod;
  logic [CW-1:0]      cnt;

  logic               accept;
  logic               mul_done;

  logic [WIDTH:0]     step_sum;
  logic [2*WIDTH-1:0] prod_nxt;
  logic               mul_ovf;
  logic [WIDTH-1:0]   mul_res;

  logic [WIDTH:0]     add_sum;
  logic [WIDTH:0]     sub_dif;
  logic [WIDTH-1:0]   alu_res;
  logic               alu_c;
  logic               alu_sets_c;

  // ---------------------------------------------------------------------
  // Control FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    in_ready  = 1'b0;
    busy      = 1'b0;
    mul_done  = 1'b0;
    case (state)
      S_IDLE: begin
        in_ready = 1'b1;
        if (in_valid && (opcode == OP_MUL)) begin
          state_nxt = S_MUL;
        end
      end
      S_MUL: begin
        busy = 1'b1;
        // The last iteration and the accumulator write share one edge, so the
        // result lands exactly WIDTH edges after the accepting edge.
        if (cnt == LAST_ITER) begin
          mul_done  = 1'b1;
          state_nxt = S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  assign accept = in_valid && in_ready;

  // ---------------------------------------------------------------------
  // Shift-add multiplier step
  // ---------------------------------------------------------------------
  always_comb begin
    step_sum = {1'b0, prod[2*WIDTH-1:WIDTH]} + (prod[0] ? {1'b0, mcand} : '0);
    prod_nxt = {step_sum, prod[WIDTH-1:1]};
    mul_ovf  = |prod_nxt[2*WIDTH-1:WIDTH];
`ifdef ACC_ALU_SAT_EN
    mul_res  = mul_ovf ? {WIDTH{1'b1}} : prod_nxt[WIDTH-1:0];
`else
    mul_res  = prod_nxt[WIDTH-1:0];
`endif
  end

  // ---------------------------------------------------------------------
  // Single-cycle operations
  // ---------------------------------------------------------------------
  always_comb begin
    add_sum    = {1'b0, acc} + {1'b0, in_val};
    sub_dif    = {1'b0, acc} - {1'b0, in_val};
    alu_res    = acc;
    alu_c      = 1'b0;
    alu_sets_c = 1'b0;
    case (opcode)
      OP_NOP: begin
        alu_res = acc;
      end
      OP_LOAD: begin
        alu_res = in_val;
      end
      OP_ADD: begin
        alu_sets_c = 1'b1;
        alu_c      = add_sum[WIDTH];
`ifdef ACC_ALU_SAT_EN
        alu_res    = add_sum[WIDTH] ? {WIDTH{1'b1}} : add_sum[WIDTH-1:0];
`else
        alu_res    = add_sum[WIDTH-1:0];
`endif
      end
      OP_SUB: begin
        // The extra top bit of the widened difference is the borrow.
        alu_sets_c = 1'b1;
        alu_c      = sub_dif[WIDTH];
`ifdef ACC_ALU_SAT_EN
        alu_res    = sub_dif[WIDTH] ? '0 : sub_dif[WIDTH-1:0];
`else
        alu_res    = sub_dif[WIDTH-1:0];
`endif
      end
      OP_AND: begin
        alu_res = acc & in_val;
      end
      OP_OR: begin
        alu_res = acc | in_val;
      end
      OP_XOR: begin
        alu_res = acc ^ in_val;
      end
      OP_SHL: begin
        alu_res = (in_val >= WIDTH_V) ? '0 : (acc << in_val);
      end
      OP_SHR: begin
        alu_res = (in_val >= WIDTH_V) ? '0 : (acc >> in_val);
      end
      default: begin
        // MUL is handled by the multiplier path; 10..15 behave as NOP.
        alu_res = acc;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Accumulator, flags and multiplier registers
  // ---------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst) begin
      acc       <= '0;
      mcand     <= '0;
      prod      <= '0;
      cnt       <= '0;
      flag_z    <= 1'b0;
      flag_c    <= 1'b0;
      flag_v    <= 1'b0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      if (mul_done) begin
        acc       <= mul_res;
        flag_v    <= mul_ovf;
        flag_z    <= (mul_res == '0);
        out_valid <= 1'b1;
      end else if (state == S_MUL) begin
        prod <= prod_nxt;
        cnt  <= cnt + CW'(1);
      end else if (accept) begin
        if (opcode == OP_MUL) begin
          mcand <= acc;
          prod  <= {{WIDTH{1'b0}}, in_val};
          cnt   <= '0;
        end else begin
          acc       <= alu_res;
          flag_z    <= (alu_res == '0);
          out_valid <= 1'b1;
          if (alu_sets_c) begin
            flag_c <= alu_c;
          end
        end
      end
    end
  end

  assign out_val = acc;

endmodule

// File: tb/tb_acc_alu.sv
// tb/tb_acc_alu.sv - directed and randomized self-checking bench for acc_alu
module tb_acc_alu;

  logic        clk;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [3:0]  opcode;
  logic [15:0] in_val;
  logic        out_valid;
  logic [15:0] out_val;
  logic        flag_z;
  logic        flag_c;
  logic        flag_v;
  logic        busy;

  int checks = 0;
  int errors = 0;

  logic [15:0] m_acc;
  logic        m_c;
  logic        m_v;
  logic        m_z;

  acc_alu #(.WIDTH(16)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .opcode    (opcode),
    .in_val    (in_val),
    .out_valid (out_valid),
    .out_val   (out_val),
    .flag_z    (flag_z),
    .flag_c    (flag_c),
    .flag_v    (flag_v),
    .busy      (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: plain unsigned arithmetic on wide integers.
  function automatic void model_apply(input logic [3:0] op, input logic [15:0] v);
    longint unsigned a;
    longint unsigned b;
    longint unsigned r;
    a = longint'(m_acc);
    b = longint'(v);
    r = a;
    case (op)
      4'd1: r = b;
      4'd2: begin
        r = a + b;
        m_c = (r > 64'hFFFF);
`ifdef ACC_ALU_SAT_EN
        if (m_c) r = 64'hFFFF;
`endif
      end
      4'd3: begin
        m_c = (b > a);
        r = m_c ? (a + 65536 - b) : (a - b);
`ifdef ACC_ALU_SAT_EN
        if (m_c) r = 0;
`endif
      end
      4'd4: begin
        r = a * b;
        m_v = (r > 64'hFFFF);
`ifdef ACC_ALU_SAT_EN
        if (m_v) r = 64'hFFFF;
`endif
      end
      4'd5: r = a & b;
      4'd6: r = a | b;
      4'd7: r = a ^ b;
      4'd8: r = (b >= 16) ? 0 : (a << b);
      4'd9: r = (b >= 16) ? 0 : (a >> b);
      default: r = a;
    endcase
    m_acc = r[15:0];
    m_z = (m_acc == 16'h0000);
  endfunction

  function automatic void model_reset();
    m_acc = 16'h0000;
    m_c = 1'b0;
    m_v = 1'b0;
    m_z = 1'b0;
  endfunction

  // Called at a negedge; returns just after the accepting posedge.
  task automatic send(input logic [3:0] op, input logic [15:0] v);
    int waitc;
    waitc = 0;
    in_valid = 1'b1;
    opcode = op;
    in_val = v;
    while (!in_ready && waitc < 100) begin
      @(negedge clk);
      waitc++;
    end
    if (waitc >= 100) check("accept_timeout", 32'(waitc), 32'd0);
    @(posedge clk);
    model_apply(op, v);
  endtask

  task automatic check_outputs(input string tag, input logic exp_ov);
    check(tag, {11'd0, out_valid, in_ready, busy, flag_z, flag_c, flag_v, out_val},
               {11'd0, exp_ov, 1'b1, 1'b0, m_z, m_c, m_v, m_acc});
  endtask

  task automatic do_single(input logic [3:0] op, input logic [15:0] v);
    send(op, v);
    @(negedge clk);
    check_outputs("single_result", 1'b1);
  endtask

  task automatic idle();
    in_valid = 1'b0;
    @(negedge clk);
    check_outputs("idle_hold", 1'b0);
  endtask

  task automatic do_mul(input logic [15:0] v);
    logic [15:0] pre_acc;
    logic        pre_z;
    logic        pre_c;
    logic        pre_v;
    pre_acc = m_acc;
    pre_z = m_z;
    pre_c = m_c;
    pre_v = m_v;
    send(4'd4, v);
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      // A competing LOAD is held during the multiply and must be ignored.
      in_valid = 1'b1;
      opcode = 4'd1;
      in_val = 16'hDEAD;
      check("mul_busy", {11'd0, out_valid, in_ready, busy, flag_z, flag_c, flag_v, out_val},
                        {11'd0, 1'b0, 1'b0, 1'b1, pre_z, pre_c, pre_v, pre_acc});
    end
    @(negedge clk);
    check_outputs("mul_result", 1'b1);
    in_valid = 1'b0;
  endtask

  task automatic do_cmd(input logic [3:0] op, input logic [15:0] v);
    if (op == 4'd4) do_mul(v);
    else do_single(op, v);
  endtask

  initial begin
    logic [3:0]  r_op;
    logic [15:0] r_v;

    // Reset with a command pending: nothing may be accepted.
    rst = 1'b0;
    in_valid = 1'b1;
    opcode = 4'd1;
    in_val = 16'h5555;
    model_reset();
    repeat (3) @(negedge clk);
    check("in_reset", {28'd0, out_valid, flag_z, flag_c, flag_v}, 32'd0);
    rst = 1'b1;
    in_valid = 1'b0;
    @(negedge clk);
    check("reset_state", {11'd0, out_valid, in_ready, busy, flag_z, flag_c, flag_v, out_val},
                         {11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});

    // LOAD then ADD back-to-back.
    do_single(4'd1, 16'h0005);
    do_single(4'd2, 16'h0003);
    check("b2b_final", {13'd0, flag_z, flag_c, out_val}, {13'd0, 1'b0, 1'b0, 16'h0008});
    idle();

    // ADD overflow and SUB underflow.
    do_single(4'd1, 16'hFFFF);
    do_single(4'd2, 16'h0002);
`ifdef ACC_ALU_SAT_EN
    check("add_ovf", {15'd0, flag_c, out_val}, {15'd0, 1'b1, 16'hFFFF});
`else
    check("add_ovf", {15'd0, flag_c, out_val}, {15'd0, 1'b1, 16'h0001});
`endif
    do_single(4'd1, 16'h0000);
    do_single(4'd3, 16'h0001);
`ifdef ACC_ALU_SAT_EN
    check("sub_unf", {15'd0, flag_c, out_val}, {15'd0, 1'b1, 16'h0000});
`else
    check("sub_unf", {15'd0, flag_c, out_val}, {15'd0, 1'b1, 16'hFFFF});
`endif
    idle();

    // Multiply timing and overflow.
    do_single(4'd1, 16'h0003);
    do_mul(16'h0007);
    check("mul_3x7", {15'd0, flag_v, out_val}, {15'd0, 1'b0, 16'h0015});
    do_single(4'd1, 16'h0100);
    do_mul(16'h0100);
`ifdef ACC_ALU_SAT_EN
    check("mul_ovf", {14'd0, flag_v, flag_z, out_val}, {14'd0, 1'b1, 1'b0, 16'hFFFF});
`else
    check("mul_ovf", {14'd0, flag_v, flag_z, out_val}, {14'd0, 1'b1, 1'b1, 16'h0000});
`endif
    idle();

    // Reset five cycles into a multiply aborts it.
    do_single(4'd1, 16'h00AB);
    send(4'd4, 16'h0011);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    model_reset();
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      check("post_abort", {11'd0, out_valid, in_ready, busy, flag_z, flag_c, flag_v, out_val},
                          {11'd0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 16'h0000});
    end
    do_single(4'd1, 16'h1234);
    check("load_after_abort", {16'd0, out_val}, {16'd0, 16'h1234});
    idle();

    // Shifts and undefined opcode.
    do_single(4'd1, 16'h0001);
    do_single(4'd8, 16'd3);
    check("shl3", {16'd0, out_val}, {16'd0, 16'h0008});
    do_single(4'd9, 16'd16);
    check("shr16", {15'd0, flag_z, out_val}, {15'd0, 1'b1, 16'h0000});
    do_single(4'd1, 16'h0ACE);
    do_single(4'd12, 16'hFFFF);
    check("op12", {15'd0, out_valid, out_val}, {15'd0, 1'b1, 16'h0ACE});
    idle();

    // Randomized commands against the reference model.
    for (int i = 0; i < 150; i++) begin
      r_op = 4'($urandom_range(0, 15));
      r_v = 16'($urandom);
      if ((r_op == 4'd8 || r_op == 4'd9) && $urandom_range(0, 1) == 1)
        r_v = 16'($urandom_range(0, 20));
      if (r_op == 4'd4 && $urandom_range(0, 1) == 1)
        r_v = 16'($urandom_range(0, 255));
      if ($urandom_range(0, 3) == 0) idle();
      do_cmd(r_op, r_v);
    end
    idle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
